maze_map: RTL and testbench
===========================

# maze_map

Cell-storage and bookkeeping stage sitting directly beside the maze solver. It holds the 64x64 wall map and answers the solver's synchronous read (`maze_oe`) and mark (`maze_we`) requests at the solver's `row`/`col`. Before solving, it accepts the wall map row by row over a valid/ready load port. After the solver raises `done`, it streams the coordinates of every marked (visited) cell over a valid/ready dump port.

## Interface
- Parameters: none; the geometry is fixed at 64 rows x 64 columns with 6-bit coordinates.
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_valid` in 1: load beat present.
- `load_ready` out 1: block accepts a load beat.
- `load_data` in 64: one row of walls; bit c = column c; 1 = wall.
- `row`, `col` in 6: solver cell address.
- `maze_oe` in 1: read request; sampled on the clock edge.
- `maze_we` in 1: mark request; sampled on the clock edge.
- `maze_in` out 1: registered wall bit of the last read cell.
- `solve_done` in 1: solver's `done` level.
- `map_ready` out 1: map loaded; solver may run.
- `path_len` out 12: number of distinct free cells marked; saturates at 4095.
- `wr_err` out 1: sticky; set by a mark attempt on a wall cell.
- `dump_valid` out 1: dump beat present.
- `dump_ready` in 1: dump beat accepted by the consumer.
- `dump_row`, `dump_col` out 6: coordinates of the marked cell being presented.
- `dump_done` out 1: scan of all 4096 cells is complete.

## Operation
- Storage: `wall[64][64]` and `mark[64][64]`. `maze_in` reflects `wall` only; marks never block the solver.
- FSM states: S_LOAD (reset state), S_SOLVE, S_DUMP, S_END.
- **S_LOAD**
  - `load_ready` = 1.
  - Each accepted beat writes `wall[load_cnt]` and clears `mark[load_cnt]`; `load_cnt` increments.
  - The beat accepted with `load_cnt` = 63 moves the FSM to S_SOLVE. Exactly 64 beats are required.
  - `maze_oe` and `maze_we` are ignored in this state.
- **S_SOLVE**
  - `map_ready` = 1.
  - `maze_oe`: `maze_in` <= `wall[row][col]`.
  - `maze_we` on a free cell: sets `mark[row][col]`. `path_len` increments only if the cell was previously unmarked.
  - `maze_we` on a wall cell: no mark; `wr_err` <= 1.
  - `maze_oe` and `maze_we` in the same cycle: both act. The read returns the wall bit, which the write does not change.
  - `solve_done` sampled high moves the FSM to S_DUMP. Scan pointer `sp` <= 0, and any `maze_oe`/`maze_we` in that cycle is ignored.
- **S_DUMP**
  - Row-major scan; `sp` = row*64 + col.
  - `dump_valid` = `mark[sp]`; `dump_row`/`dump_col` = `sp[11:6]`/`sp[5:0]`.
  - `sp` advances when `!mark[sp]` or `dump_ready`. The presented beat holds stable while `dump_ready` = 0.
  - Advancing from `sp` = 4095 moves the FSM to S_END.
- **S_END**
  - `dump_done` = 1 and `dump_valid` = 0.
  - Holds until reset. All inputs are ignored.
- Reset mid-operation: state returns to S_LOAD and `load_cnt` = 0. Wall and mark contents are undefined until reloaded; each load beat reclears its row's marks.

## Timing
- Reset values:
  - `load_ready` = 1, `maze_in` = 1.
  - `map_ready`, `path_len`, `wr_err`, `dump_valid`, `dump_row`, `dump_col`, `dump_done` = 0.
- `maze_in` changes only on a clock edge with `maze_oe` = 1 in S_SOLVE, and then holds until the next such read.
- Read latency: `maze_oe` sampled at edge t -> `maze_in` valid after edge t, i.e. usable by the solver in cycle t+1.
- Mark latency: a mark is visible to `path_len` and the dump after the sampling edge.
- `map_ready` rises the edge after the 64th load handshake.
- Dump: if no cells are stalled and none is marked before cell i, cell i is examined i cycles after S_DUMP entry. An unmarked cell costs 1 cycle; a marked cell costs 1 cycle plus its stall cycles.
- `dump_done` rises exactly 4096 + (total stall cycles) cycles after S_DUMP entry.
- `path_len` saturates: at 4095, further new marks leave it at 4095.

## Test plan
- **Load handshake:** reset, then drive 64 beats, with `load_valid` dropped for 3 cycles mid-stream -> `map_ready` = 1 only after beat 64. `maze_oe` at (5,7), with bit 7 of row 5 = 1 -> `maze_in` = 1 the next cycle.
- **Mark counting:** in S_SOLVE, issue `maze_we` at (1,1), (1,2), (1,1) -> `path_len` = 2.
- **Wall write:** issue `maze_we` on a wall cell -> `wr_err` = 1 and sticky, `path_len` unchanged, cell absent from the dump.
- **Dump order and backpressure:** mark (0,3), (2,0), (63,63). Assert `solve_done`, then hold `dump_ready` = 0 for 5 cycles on the first beat -> beats (0,3), (2,0), (63,63) in that order, the first held stable while stalled. `dump_done` rises 4096 + 5 cycles after S_DUMP entry.
- **Empty dump:** assert `solve_done` with no marks -> `dump_valid` never rises; `dump_done` rises after 4096 cycles.
- **Reset mid-dump:** pull `rst_n` low during S_DUMP -> all outputs return to reset values immediately (`maze_in` = 1, `dump_valid` = 0). A reload then gives `path_len` = 0 and an empty dump.

Source files
------------

// File: rtl/maze_map.sv
// Wall map and visit-mark storage beside the maze solver: row-wise load,
// synchronous read/mark service for the solver, then a row-major dump of marked cells.
module maze_map (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [63:0] load_data,
    input  logic [5:0]  row,
    input  logic [5:0]  col,
    input  logic        maze_oe,
    input  logic        maze_we,
    output logic        maze_in,
    input  logic        solve_done,
    output logic        map_ready,
    output logic [11:0] path_len,
    output logic        wr_err,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [5:0]  dump_row,
    output logic [5:0]  dump_col,
    output logic        dump_done
);

    typedef enum logic [1:0] {S_LOAD, S_SOLVE, S_DUMP, S_END} state_e;

    state_e      state_q;
    logic [5:0]  loadCnt_q;
    logic [11:0] sp_q;
    logic [11:0] pathLen_q;
    logic [11:0] pathLen_d;
    logic        mazeIn_q;
    logic        wrErr_q;

    logic [63:0] wall_q [64];
    logic [63:0] mark_q [64];

    logic loadFire;
    logic solveAct;
    logic cellWall;
    logic cellMark;
    logic spMark;
    logic spAdvance;

    // The solve_done cycle is excluded from solver service so no mark lands after the dump starts.
    always_comb begin
        loadFire  = (state_q == S_LOAD) && load_valid;
        solveAct  = (state_q == S_SOLVE) && !solve_done;
        cellWall  = wall_q[row][col];
        cellMark  = mark_q[row][col];
        spMark    = mark_q[sp_q[11:6]][sp_q[5:0]];
        spAdvance = (state_q == S_DUMP) && (!spMark || dump_ready);
        pathLen_d = pathLen_q;
        if (solveAct && maze_we && !cellWall && !cellMark && (pathLen_q != 12'hFFF)) begin
            pathLen_d = pathLen_q + 12'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (loadFire) begin
            wall_q[loadCnt_q] <= load_data;
            mark_q[loadCnt_q] <= '0;
        end else if (solveAct && maze_we && !cellWall) begin
            mark_q[row][col] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_LOAD;
            loadCnt_q <= '0;
            sp_q      <= '0;
            pathLen_q <= '0;
            mazeIn_q  <= 1'b1;
            wrErr_q   <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (loadFire) begin
                        loadCnt_q <= loadCnt_q + 6'd1;
                        if (loadCnt_q == 6'd63) begin
                            state_q <= S_SOLVE;
                        end
                    end
                end
                S_SOLVE: begin
                    if (solve_done) begin
                        state_q <= S_DUMP;
                        sp_q    <= '0;
                    end else begin
                        if (maze_oe) begin
                            mazeIn_q <= cellWall;
                        end
                        if (maze_we && cellWall) begin
                            wrErr_q <= 1'b1;
                        end
                        pathLen_q <= pathLen_d;
                    end
                end
                S_DUMP: begin
                    if (spAdvance) begin
                        sp_q <= sp_q + 12'd1;
                        if (sp_q == 12'hFFF) begin
                            state_q <= S_END;
                        end
                    end
                end
                default: begin
                    state_q <= S_END;
                end
            endcase
        end
    end

    always_comb begin
        load_ready = (state_q == S_LOAD);
        map_ready  = (state_q == S_SOLVE);
        dump_valid = (state_q == S_DUMP) && spMark;
        dump_done  = (state_q == S_END);
        dump_row   = sp_q[11:6];
        dump_col   = sp_q[5:0];
        maze_in    = mazeIn_q;
        path_len   = pathLen_q;
        wr_err     = wrErr_q;
    end

endmodule

// File: tb/tb_maze_map.sv
// Directed bench for maze_map: load, read/mark, wall writes, dump order with
// backpressure, empty dump and reset in the middle of a dump.
module tb_maze_map;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [63:0] load_data;
    logic [5:0]  row;
    logic [5:0]  col;
    logic        maze_oe;
    logic        maze_we;
    logic        maze_in;
    logic        solve_done;
    logic        map_ready;
    logic [11:0] path_len;
    logic        wr_err;
    logic        dump_valid;
    logic        dump_ready;
    logic [5:0]  dump_row;
    logic [5:0]  dump_col;
    logic        dump_done;

    int checks = 0;
    int errors = 0;

    maze_map dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .row        (row),
        .col        (col),
        .maze_oe    (maze_oe),
        .maze_we    (maze_we),
        .maze_in    (maze_in),
        .solve_done (solve_done),
        .map_ready  (map_ready),
        .path_len   (path_len),
        .wr_err     (wr_err),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_row   (dump_row),
        .dump_col   (dump_col),
        .dump_done  (dump_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One solver cycle: present the request, let one edge sample it, then idle the strobes.
    task automatic applyStimulus(input logic oe, input logic we, input logic [5:0] r, input logic [5:0] c);
        maze_oe = oe;
        maze_we = we;
        row     = r;
        col     = c;
        tick();
        maze_oe = 1'b0;
        maze_we = 1'b0;
    endtask

    function automatic logic [63:0] rowWalls(input int r);
        if (r == 5)  return 64'h80;
        if (r == 10) return 64'h1;
        return 64'h0;
    endfunction

    task automatic loadMap(input bit withGap);
        for (int i = 0; i < 64; i++) begin
            if (withGap && i == 32) begin
                load_valid = 1'b0;
                for (int g = 0; g < 3; g++) tick();
                checkOutput("map_ready_during_gap", 32'(map_ready), 32'd0);
            end
            load_valid = 1'b1;
            load_data  = rowWalls(i);
            if (i == 63) checkOutput("map_ready_before_last", 32'(map_ready), 32'd0);
            tick();
        end
        load_valid = 1'b0;
        checkOutput("map_ready_after_load", 32'(map_ready), 32'd1);
        checkOutput("load_ready_after_load", 32'(load_ready), 32'd0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_load_ready", 32'(load_ready), 32'd1);
        checkOutput("rst_maze_in",    32'(maze_in),    32'd1);
        checkOutput("rst_map_ready",  32'(map_ready),  32'd0);
        checkOutput("rst_path_len",   32'(path_len),   32'd0);
        checkOutput("rst_wr_err",     32'(wr_err),     32'd0);
        checkOutput("rst_dump_valid", 32'(dump_valid), 32'd0);
        checkOutput("rst_dump_row",   32'(dump_row),   32'd0);
        checkOutput("rst_dump_col",   32'(dump_col),   32'd0);
        checkOutput("rst_dump_done",  32'(dump_done),  32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [11:0] expBeats [5] = '{12'd3, 12'd65, 12'd66, 12'd128, 12'd4095};

    initial begin
        int nBeats;
        int stall;
        int doneCyc;
        int cyc;

        rst_n      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        row        = '0;
        col        = '0;
        maze_oe    = 1'b0;
        maze_we    = 1'b0;
        solve_done = 1'b0;
        dump_ready = 1'b1;
        #2;

        doReset();
        loadMap(1'b1);

        applyStimulus(1'b1, 1'b0, 6'd5, 6'd7);
        checkOutput("read_wall_5_7", 32'(maze_in), 32'd1);
        applyStimulus(1'b1, 1'b0, 6'd5, 6'd6);
        checkOutput("read_free_5_6", 32'(maze_in), 32'd0);
        applyStimulus(1'b0, 1'b0, 6'd5, 6'd7);
        checkOutput("maze_in_hold", 32'(maze_in), 32'd0);

        applyStimulus(1'b0, 1'b1, 6'd1, 6'd1);
        applyStimulus(1'b0, 1'b1, 6'd1, 6'd2);
        applyStimulus(1'b0, 1'b1, 6'd1, 6'd1);
        checkOutput("path_len_dup", 32'(path_len), 32'd2);
        checkOutput("wr_err_clean", 32'(wr_err), 32'd0);

        applyStimulus(1'b0, 1'b1, 6'd10, 6'd0);
        checkOutput("wr_err_set", 32'(wr_err), 32'd1);
        checkOutput("path_len_wall", 32'(path_len), 32'd2);
        applyStimulus(1'b0, 1'b0, 6'd0, 6'd0);
        checkOutput("wr_err_sticky", 32'(wr_err), 32'd1);

        applyStimulus(1'b1, 1'b1, 6'd0, 6'd3);
        checkOutput("oe_we_read", 32'(maze_in), 32'd0);
        checkOutput("oe_we_mark", 32'(path_len), 32'd3);
        applyStimulus(1'b0, 1'b1, 6'd2, 6'd0);
        applyStimulus(1'b0, 1'b1, 6'd63, 6'd63);
        checkOutput("path_len_5", 32'(path_len), 32'd5);

        // The mark issued alongside solve_done must not show up in the dump or the count.
        solve_done = 1'b1;
        maze_we    = 1'b1;
        row        = 6'd3;
        col        = 6'd3;
        tick();
        solve_done = 1'b0;
        maze_we    = 1'b0;
        checkOutput("path_len_at_dump", 32'(path_len), 32'd5);

        nBeats  = 0;
        stall   = 0;
        doneCyc = -1;
        cyc     = 0;
        while (cyc < 5000) begin
            if (dump_done) begin
                doneCyc = cyc;
                break;
            end
            dump_ready = 1'b1;
            if (dump_valid) begin
                if (nBeats == 0 && stall < 5) begin
                    dump_ready = 1'b0;
                    checkOutput("stall_beat_stable", 32'({dump_row, dump_col}), 32'd3);
                    stall++;
                end else begin
                    if (nBeats < 5) checkOutput("dump_beat", 32'({dump_row, dump_col}), 32'(expBeats[nBeats]));
                    nBeats++;
                end
            end
            tick();
            cyc++;
        end
        dump_ready = 1'b1;
        checkOutput("dump_beat_count", 32'(nBeats), 32'd5);
        checkOutput("dump_done_cycle", 32'(doneCyc), 32'd4101);
        checkOutput("end_dump_valid", 32'(dump_valid), 32'd0);
        tick();
        checkOutput("end_dump_done_hold", 32'(dump_done), 32'd1);

        doReset();
        loadMap(1'b0);
        applyStimulus(1'b0, 1'b1, 6'd1, 6'd1);
        applyStimulus(1'b1, 1'b0, 6'd5, 6'd6);
        checkOutput("run2_maze_in", 32'(maze_in), 32'd0);
        solve_done = 1'b1;
        tick();
        solve_done = 1'b0;
        dump_ready = 1'b0;
        for (int i = 0; i < 70; i++) tick();
        checkOutput("mid_dump_valid", 32'(dump_valid), 32'd1);
        checkOutput("mid_dump_cell", 32'({dump_row, dump_col}), 32'd65);
        dump_ready = 1'b1;
        doReset();

        loadMap(1'b0);
        checkOutput("reload_path_len", 32'(path_len), 32'd0);
        solve_done = 1'b1;
        tick();
        solve_done = 1'b0;
        nBeats  = 0;
        doneCyc = -1;
        cyc     = 0;
        while (cyc < 5000) begin
            if (dump_done) begin
                doneCyc = cyc;
                break;
            end
            if (dump_valid) nBeats++;
            tick();
            cyc++;
        end
        checkOutput("empty_dump_beats", 32'(nBeats), 32'd0);
        checkOutput("empty_dump_done_cycle", 32'(doneCyc), 32'd4096);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
